// File: rtl/block_window_loader.sv
// Scans a time-sorted block memory each frame into a shadow bank of up to NUM_SLOTS upcoming blocks.
// The shadow bank is committed to the active outputs in one cycle; sliced block IDs are hidden.
module block_window_loader #(
    parameter int unsigned NUM_SLOTS = 12,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [17:0] LOOKAHEAD = 18'd2048,
    parameter logic [17:0] BEHIND    = 18'd256,
    parameter int unsigned Z_SHIFT   = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           frame_start_in,
    input  logic [17:0]                    curr_time_in,
    output logic [ADDR_W-1:0]              mem_addr_out,
    input  logic [45:0]                    mem_data_in,
    input  logic                           slice_valid_in,
    input  logic [7:0]                     slice_id_in,
    output logic [NUM_SLOTS-1:0][11:0]     block_x_out,
    output logic [NUM_SLOTS-1:0][11:0]     block_y_out,
    output logic [NUM_SLOTS-1:0][13:0]     block_z_out,
    output logic [NUM_SLOTS-1:0]           block_color_out,
    output logic [NUM_SLOTS-1:0][2:0]      block_direction_out,
    output logic [NUM_SLOTS-1:0][7:0]      block_ID_out,
    output logic [NUM_SLOTS-1:0]           block_visible_out,
    output logic                           busy_out,
    output logic                           ready_out
);

    typedef enum logic [1:0] {StIdle, StFetch, StEval, StCommit} state_e;

    state_e                       state_q;
    logic [17:0]                  frame_t_q;
    logic [ADDR_W-1:0]            ptr_q;
    logic [ADDR_W-1:0]            scan_base_q;
    logic [3:0]                   count_q;
    logic [MEM_DEPTH-1:0]         bitmap_q;
    logic [NUM_SLOTS-1:0][11:0]   sh_x;
    logic [NUM_SLOTS-1:0][11:0]   sh_y;
    logic [NUM_SLOTS-1:0][13:0]   sh_z;
    logic [NUM_SLOTS-1:0]         sh_color;
    logic [NUM_SLOTS-1:0][2:0]    sh_dir;
    logic [NUM_SLOTS-1:0][7:0]    sh_id;
    logic [NUM_SLOTS-1:0]         sh_vis;

    logic [17:0] t;
    logic [18:0] t19;
    logic [18:0] f19;
    logic        is_end;
    logic        is_stale;
    logic        is_far;
    logic        ptr_last;
    logic        slice_hit_ptr;
    logic [17:0] delta;
    logic [17:0] dshift;
    logic [13:0] z_val;

    assign mem_addr_out = ptr_q;

    always_comb begin
        t             = mem_data_in[45:28];
        t19           = {1'b0, t};
        f19           = {1'b0, frame_t_q};
        is_end        = (t == 18'h3FFFF);
        is_stale      = (t19 + {1'b0, BEHIND}) < f19;
        is_far        = t19 > (f19 + {1'b0, LOOKAHEAD});
        ptr_last      = (ptr_q == ADDR_W'(MEM_DEPTH - 1));
        slice_hit_ptr = slice_valid_in && (ADDR_W'(slice_id_in) == ptr_q);
        delta         = (t >= frame_t_q) ? (t - frame_t_q) : 18'd0;
        dshift        = delta >> Z_SHIFT;
        z_val         = (dshift > 18'h3FFF) ? 14'h3FFF : dshift[13:0];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q             <= StIdle;
            frame_t_q           <= '0;
            ptr_q               <= '0;
            scan_base_q         <= '0;
            count_q             <= '0;
            bitmap_q            <= '0;
            sh_x                <= '0;
            sh_y                <= '0;
            sh_z                <= '0;
            sh_color            <= '0;
            sh_dir              <= '0;
            sh_id               <= '0;
            sh_vis              <= '0;
            block_x_out         <= '0;
            block_y_out         <= '0;
            block_z_out         <= '0;
            block_color_out     <= '0;
            block_direction_out <= '0;
            block_ID_out        <= '0;
            block_visible_out   <= '0;
            busy_out            <= 1'b0;
            ready_out           <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            if (slice_valid_in) begin
                bitmap_q[slice_id_in] <= 1'b1;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (block_ID_out[i] == slice_id_in) block_visible_out[i] <= 1'b0;
                    if (sh_id[i] == slice_id_in) sh_vis[i] <= 1'b0;
                end
            end
            if (frame_start_in) begin
                // Restart even mid-load; scan_base progress is intentionally kept.
                frame_t_q <= curr_time_in;
                count_q   <= '0;
                ptr_q     <= scan_base_q;
                sh_vis    <= '0;
                busy_out  <= 1'b1;
                state_q   <= StFetch;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StFetch: state_q <= StEval;
                    StEval: begin
                        if (is_end) begin
                            state_q <= StCommit;
                        end else if (is_stale) begin
                            if (ptr_q == scan_base_q && !ptr_last) begin
                                scan_base_q <= scan_base_q + ADDR_W'(1);
                            end
                            if (ptr_last) begin
                                state_q <= StCommit;
                            end else begin
                                ptr_q   <= ptr_q + ADDR_W'(1);
                                state_q <= StFetch;
                            end
                        end else if (is_far) begin
                            state_q <= StCommit;
                        end else begin
                            sh_x[count_q]     <= mem_data_in[27:16];
                            sh_y[count_q]     <= mem_data_in[15:4];
                            sh_color[count_q] <= mem_data_in[3];
                            sh_dir[count_q]   <= mem_data_in[2:0];
                            sh_id[count_q]    <= 8'(ptr_q);
                            sh_z[count_q]     <= z_val;
                            // A slice landing on this very entry must not slip through.
                            sh_vis[count_q]   <= !(bitmap_q[ptr_q] || slice_hit_ptr);
                            count_q           <= count_q + 4'd1;
                            if (count_q == 4'(NUM_SLOTS - 1) || ptr_last) begin
                                state_q <= StCommit;
                            end else begin
                                ptr_q   <= ptr_q + ADDR_W'(1);
                                state_q <= StFetch;
                            end
                        end
                    end
                    StCommit: begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (4'(i) < count_q) begin
                                block_x_out[i]         <= sh_x[i];
                                block_y_out[i]         <= sh_y[i];
                                block_z_out[i]         <= sh_z[i];
                                block_color_out[i]     <= sh_color[i];
                                block_direction_out[i] <= sh_dir[i];
                                block_ID_out[i]        <= sh_id[i];
                                block_visible_out[i]   <= sh_vis[i] &&
                                    !(slice_valid_in && sh_id[i] == slice_id_in);
                            end else begin
                                block_x_out[i]         <= '0;
                                block_y_out[i]         <= '0;
                                block_z_out[i]         <= '0;
                                block_color_out[i]     <= 1'b0;
                                block_direction_out[i] <= '0;
                                block_ID_out[i]        <= '0;
                                block_visible_out[i]   <= 1'b0;
                            end
                        end
                        ready_out <= 1'b1;
                        busy_out  <= 1'b0;
                        state_q   <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_window_loader.sv
// Directed bench for block_window_loader: table of frame loads plus hand-written corner sequences.
module tb_block_window_loader;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b0;
    logic                frame_start_in = 1'b0;
    logic [17:0]         curr_time_in = '0;
    logic                slice_valid_in = 1'b0;
    logic [7:0]          slice_id_in = '0;

    logic [7:0]          addr0, addr1;
    logic [45:0]         rd0 = '0, rd1 = '0;
    logic [45:0]         mem [256];

    logic [11:0][11:0]   x0, y0, x1, y1;
    logic [11:0][13:0]   z0, z1;
    logic [11:0]         col0, col1, vis0, vis1;
    logic [11:0][2:0]    dir0, dir1;
    logic [11:0][7:0]    id0, id1;
    logic                busy0, busy1, ready0, ready1;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    always_ff @(posedge clk_in) begin
        rd0 <= mem[addr0];
        rd1 <= mem[addr1];
    end

    block_window_loader dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .curr_time_in(curr_time_in), .mem_addr_out(addr0), .mem_data_in(rd0),
        .slice_valid_in(slice_valid_in), .slice_id_in(slice_id_in),
        .block_x_out(x0), .block_y_out(y0), .block_z_out(z0), .block_color_out(col0),
        .block_direction_out(dir0), .block_ID_out(id0), .block_visible_out(vis0),
        .busy_out(busy0), .ready_out(ready0)
    );

    block_window_loader #(.LOOKAHEAD(18'h3FFFE)) dut_wide (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .curr_time_in(curr_time_in), .mem_addr_out(addr1), .mem_data_in(rd1),
        .slice_valid_in(slice_valid_in), .slice_id_in(slice_id_in),
        .block_x_out(x1), .block_y_out(y1), .block_z_out(z1), .block_color_out(col1),
        .block_direction_out(dir1), .block_ID_out(id1), .block_visible_out(vis1),
        .busy_out(busy1), .ready_out(ready1)
    );

    typedef struct {
        logic [17:0] frame_t;
        int          lat;
        int          cnt;
        logic [11:0] vis;
        int          slot;
        logic [7:0]  id;
        logic [13:0] z;
        logic [11:0] x;
        logic        col;
        logic [2:0]  dir;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [17:0] t);
        @(negedge clk_in);
        curr_time_in   = t;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    // Returns cycles from the frame_start cycle to the ready_out cycle (300 on timeout).
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!ready0 && cyc < 300) begin
            @(negedge clk_in);
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        vec_t vecs[4];
        int   cyc;
        int   nready;

        // Entry i: time 100*(i+1), x 16i+5, y 200+i, color i[0], dir i%8; end marker at 15.
        for (int i = 0; i < 256; i++) mem[i] = {18'h3FFFF, 28'h0};
        for (int i = 0; i < 15; i++) begin
            logic [31:0] iv;
            iv = i;
            mem[i] = {18'(100 * (i + 1)), 12'(16 * i + 5), 12'(200 + i), iv[0], iv[2:0]};
        end

        vecs[0] = '{frame_t: 18'd0,    lat: 26, cnt: 12, vis: 12'hFFF, slot: 0,
                    id: 8'd0,  z: 14'd25,  x: 12'd5,   col: 1'b0, dir: 3'd0};
        vecs[1] = '{frame_t: 18'd1000, lat: 34, cnt: 8,  vis: 12'h0FF, slot: 6,
                    id: 8'd13, z: 14'd100, x: 12'd213, col: 1'b1, dir: 3'd5};
        vecs[2] = '{frame_t: 18'd1200, lat: 20, cnt: 6,  vis: 12'h03F, slot: 5,
                    id: 8'd14, z: 14'd75,  x: 12'd229, col: 1'b0, dir: 3'd6};
        vecs[3] = '{frame_t: 18'd3000, lat: 16, cnt: 0,  vis: 12'h000, slot: 0,
                    id: 8'd0,  z: 14'd0,   x: 12'd0,   col: 1'b0, dir: 3'd0};

        #2;
        check("reset_vis_async", {20'd0, vis0}, 32'd0);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("reset_ready", {31'd0, ready0}, 32'd0);
        check("reset_addr", {24'd0, addr0}, 32'd0);
        check("reset_id1", {24'd0, id0[1]}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].frame_t);
            check($sformatf("v%0d_busy", v), {31'd0, busy0}, 32'd1);
            wait_ready(cyc);
            check($sformatf("v%0d_latency", v), cyc, vecs[v].lat);
            check($sformatf("v%0d_vis", v), {20'd0, vis0}, {20'd0, vecs[v].vis});
            check($sformatf("v%0d_id", v), {24'd0, id0[vecs[v].slot]}, {24'd0, vecs[v].id});
            check($sformatf("v%0d_z", v), {18'd0, z0[vecs[v].slot]}, {18'd0, vecs[v].z});
            check($sformatf("v%0d_x", v), {20'd0, x0[vecs[v].slot]}, {20'd0, vecs[v].x});
            check($sformatf("v%0d_col", v), {31'd0, col0[vecs[v].slot]}, {31'd0, vecs[v].col});
            check($sformatf("v%0d_dir", v), {29'd0, dir0[vecs[v].slot]}, {29'd0, vecs[v].dir});
            if (vecs[v].cnt < 12) begin
                check($sformatf("v%0d_zero_id", v), {24'd0, id0[vecs[v].cnt]}, 32'd0);
                check($sformatf("v%0d_zero_x", v), {20'd0, x0[vecs[v].cnt]}, 32'd0);
            end
            @(negedge clk_in);
            check($sformatf("v%0d_ready_pulse", v), {31'd0, ready0}, 32'd0);
            check($sformatf("v%0d_busy_low", v), {31'd0, busy0}, 32'd0);
        end

        // Slice an active block, then confirm a reload keeps it hidden.
        pulse_reset();
        start_frame(18'd0);
        wait_ready(cyc);
        check("slice_pre_vis", {20'd0, vis0}, 32'hFFF);
        slice_valid_in = 1'b1;
        slice_id_in    = 8'd3;
        @(negedge clk_in);
        slice_valid_in = 1'b0;
        check("slice_active_vis", {20'd0, vis0}, 32'hFF7);
        start_frame(18'd0);
        wait_ready(cyc);
        check("slice_reload_vis", {20'd0, vis0}, 32'hFF7);
        check("slice_reload_id3", {24'd0, id0[3]}, 32'd3);

        // Asynchronous reset in the middle of a load.
        start_frame(18'd0);
        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        #2;
        check("midrst_vis", {20'd0, vis0}, 32'd0);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_id1", {24'd0, id0[1]}, 32'd0);
        check("midrst_x1", {20'd0, x0[1]}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        start_frame(18'd0);
        wait_ready(cyc);
        check("midrst_bitmap_clear", {20'd0, vis0}, 32'hFFF);

        // Restart mid-load: one ready, bank reflects the second frame time.
        start_frame(18'd0);
        repeat (4) @(negedge clk_in);
        check("abort_bank_kept", {24'd0, id0[1]}, 32'd1);
        check("abort_busy", {31'd0, busy0}, 32'd1);
        start_frame(18'd500);
        nready = 0;
        for (int c = 0; c < 80; c++) begin
            if (ready0) nready++;
            @(negedge clk_in);
        end
        check("abort_ready_count", nready, 1);
        check("abort_id0", {24'd0, id0[0]}, 32'd2);
        check("abort_z3", {18'd0, z0[3]}, 32'd25);
        check("abort_vis", {20'd0, vis0}, 32'hFFF);

        // Far-future entry: default lookahead commits empty, wide lookahead saturates z.
        pulse_reset();
        mem[0] = {18'd70000, 12'd9, 12'd8, 1'b1, 3'd2};
        mem[1] = {18'h3FFFF, 28'h0};
        start_frame(18'd0);
        wait_ready(cyc);
        check("far_latency", cyc, 4);
        check("far_vis", {20'd0, vis0}, 32'd0);
        check("far_id0", {24'd0, id0[0]}, 32'd0);
        repeat (4) @(negedge clk_in);
        check("sat_z", {18'd0, z1[0]}, 32'h3FFF);
        check("sat_vis", {20'd0, vis1}, 32'h001);
        check("sat_x", {20'd0, x1[0]}, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
